// File: rtl/axi_mem_arbiter.sv
`timescale 1ns/1ps
// axi_mem_arbiter: two-master, one-slave AXI4 arbiter for the core memory port.
// Master 0 is the instruction fetch unit (read only). Master 1 is the load/store
// path (read and write). Ownership is granted per transaction, and a master
// keeps the slave port until its last R beat or its B response completes.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   m0_ar*, m0_r*     IFU read address / read data channels
//   m1_ar*, m1_r*     LSU read address / read data channels
//   m1_aw*, m1_w*,    LSU write address / write data / write response channels
//   m1_b*
//   s_ar*, s_r*,      shared slave-side AXI port
//   s_aw*, s_w*, s_b*
//   grant             one-hot owner (01 = m0, 10 = m1, 00 = none), registered
//   busy              high whenever a transaction owns the port
module axi_mem_arbiter #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ID_W     = 4,
   parameter int unsigned LSU_PRIO = 1
) (
   input  logic                clk,
   input  logic                rst,
   // IFU read
   input  logic                m0_arvalid,
   output logic                m0_arready,
   input  logic [ADDR_W-1:0]   m0_araddr,
   input  logic [ID_W-1:0]     m0_arid,
   input  logic [7:0]          m0_arlen,
   input  logic [2:0]          m0_arsize,
   input  logic [1:0]          m0_arburst,
   output logic                m0_rvalid,
   input  logic                m0_rready,
   output logic [DATA_W-1:0]   m0_rdata,
   output logic [1:0]          m0_rresp,
   output logic                m0_rlast,
   output logic [ID_W-1:0]     m0_rid,
   // LSU read
   input  logic                m1_arvalid,
   output logic                m1_arready,
   input  logic [ADDR_W-1:0]   m1_araddr,
   input  logic [ID_W-1:0]     m1_arid,
   input  logic [7:0]          m1_arlen,
   input  logic [2:0]          m1_arsize,
   input  logic [1:0]          m1_arburst,
   output logic                m1_rvalid,
   input  logic                m1_rready,
   output logic [DATA_W-1:0]   m1_rdata,
   output logic [1:0]          m1_rresp,
   output logic                m1_rlast,
   output logic [ID_W-1:0]     m1_rid,
   // LSU write
   input  logic                m1_awvalid,
   output logic                m1_awready,
   input  logic [ADDR_W-1:0]   m1_awaddr,
   input  logic [ID_W-1:0]     m1_awid,
   input  logic [7:0]          m1_awlen,
   input  logic [2:0]          m1_awsize,
   input  logic [1:0]          m1_awburst,
   input  logic                m1_wvalid,
   output logic                m1_wready,
   input  logic [DATA_W-1:0]   m1_wdata,
   input  logic [DATA_W/8-1:0] m1_wstrb,
   input  logic                m1_wlast,
   output logic                m1_bvalid,
   input  logic                m1_bready,
   output logic [1:0]          m1_bresp,
   output logic [ID_W-1:0]     m1_bid,
   // slave side
   output logic                s_arvalid,
   input  logic                s_arready,
   output logic [ADDR_W-1:0]   s_araddr,
   output logic [ID_W-1:0]     s_arid,
   output logic [7:0]          s_arlen,
   output logic [2:0]          s_arsize,
   output logic [1:0]          s_arburst,
   input  logic                s_rvalid,
   output logic                s_rready,
   input  logic [DATA_W-1:0]   s_rdata,
   input  logic [1:0]          s_rresp,
   input  logic                s_rlast,
   input  logic [ID_W-1:0]     s_rid,
   output logic                s_awvalid,
   input  logic                s_awready,
   output logic [ADDR_W-1:0]   s_awaddr,
   output logic [ID_W-1:0]     s_awid,
   output logic [7:0]          s_awlen,
   output logic [2:0]          s_awsize,
   output logic [1:0]          s_awburst,
   output logic                s_wvalid,
   input  logic                s_wready,
   output logic [DATA_W-1:0]   s_wdata,
   output logic [DATA_W/8-1:0] s_wstrb,
   output logic                s_wlast,
   input  logic                s_bvalid,
   output logic                s_bready,
   input  logic [1:0]          s_bresp,
   input  logic [ID_W-1:0]     s_bid,
   // status
   output logic [1:0]          grant,
   output logic                busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RD_M0 = 2'd1,
      RD_M1 = 2'd2,
      WR_M1 = 2'd3
   } state_t;

   state_t     state, state_next;
   logic [1:0] grant_next;
   logic       rr, rr_next;          // 0 favours m0 on the next contested read
   logic       ar_done, aw_done, w_done;
   logic       ar_fire, aw_fire, w_last_fire, r_last_fire, b_fire;

   // Handshake events on the slave side
   assign ar_fire     = s_arvalid & s_arready;
   assign aw_fire     = s_awvalid & s_awready;
   assign w_last_fire = s_wvalid & s_wready & s_wlast;
   assign r_last_fire = s_rvalid & s_rready & s_rlast;
   assign b_fire      = s_bvalid & s_bready;

   assign busy = (state != IDLE);

   // State, grant, round-robin pointer and per-channel done flags
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         grant   <= 2'b00;
         rr      <= 1'b0;
         ar_done <= 1'b0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         state <= state_next;
         grant <= grant_next;
         rr    <= rr_next;
         if (state == IDLE) begin
            ar_done <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
         end else begin
            if (ar_fire)     ar_done <= 1'b1;
            if (aw_fire)     aw_done <= 1'b1;
            if (w_last_fire) w_done  <= 1'b1;
         end
      end
   end

   // Arbitration (IDLE only) and release
   always_comb begin
      state_next = state;
      rr_next    = rr;
      case (state)
         IDLE: begin
            if (m1_awvalid) begin
               state_next = WR_M1;
            end else if (m1_arvalid && m0_arvalid) begin
               if (LSU_PRIO != 0) begin
                  state_next = RD_M1;
               end else begin
                  state_next = rr ? RD_M1 : RD_M0;
                  rr_next    = ~rr;
               end
            end else if (m1_arvalid) begin
               state_next = RD_M1;
            end else if (m0_arvalid) begin
               state_next = RD_M0;
            end
         end
         RD_M0, RD_M1: begin
            if (r_last_fire) state_next = IDLE;
         end
         WR_M1: begin
            if (b_fire) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase

      case (state_next)
         RD_M0:        grant_next = 2'b01;
         RD_M1, WR_M1: grant_next = 2'b10;
         default:      grant_next = 2'b00;
      endcase
   end

   // Handshake routing; every valid/ready is 0 unless the owner's channel is open
   always_comb begin
      m0_arready = 1'b0;
      m0_rvalid  = 1'b0;
      m1_arready = 1'b0;
      m1_rvalid  = 1'b0;
      m1_awready = 1'b0;
      m1_wready  = 1'b0;
      m1_bvalid  = 1'b0;
      s_arvalid  = 1'b0;
      s_rready   = 1'b0;
      s_awvalid  = 1'b0;
      s_wvalid   = 1'b0;
      s_bready   = 1'b0;
      case (state)
         RD_M0: begin
            s_arvalid  = m0_arvalid & ~ar_done;
            m0_arready = s_arready & ~ar_done;
            m0_rvalid  = s_rvalid;
            s_rready   = m0_rready;
         end
         RD_M1: begin
            s_arvalid  = m1_arvalid & ~ar_done;
            m1_arready = s_arready & ~ar_done;
            m1_rvalid  = s_rvalid;
            s_rready   = m1_rready;
         end
         WR_M1: begin
            s_awvalid  = m1_awvalid & ~aw_done;
            m1_awready = s_awready & ~aw_done;
            s_wvalid   = m1_wvalid & ~w_done;
            m1_wready  = s_wready & ~w_done;
            m1_bvalid  = s_bvalid;
            s_bready   = m1_bready;
         end
         default: ;
      endcase
   end

   // Payloads pass through; they are only meaningful while the matching valid is high
   assign s_araddr  = (state == RD_M1) ? m1_araddr  : m0_araddr;
   assign s_arid    = (state == RD_M1) ? m1_arid    : m0_arid;
   assign s_arlen   = (state == RD_M1) ? m1_arlen   : m0_arlen;
   assign s_arsize  = (state == RD_M1) ? m1_arsize  : m0_arsize;
   assign s_arburst = (state == RD_M1) ? m1_arburst : m0_arburst;

   assign m0_rdata = s_rdata;
   assign m0_rresp = s_rresp;
   assign m0_rlast = s_rlast;
   assign m0_rid   = s_rid;
   assign m1_rdata = s_rdata;
   assign m1_rresp = s_rresp;
   assign m1_rlast = s_rlast;
   assign m1_rid   = s_rid;

   assign s_awaddr  = m1_awaddr;
   assign s_awid    = m1_awid;
   assign s_awlen   = m1_awlen;
   assign s_awsize  = m1_awsize;
   assign s_awburst = m1_awburst;
   assign s_wdata   = m1_wdata;
   assign s_wstrb   = m1_wstrb;
   assign s_wlast   = m1_wlast;

   assign m1_bresp = s_bresp;
   assign m1_bid   = s_bid;

endmodule

// File: tb/tb_axi_mem_arbiter.sv
`timescale 1ns/1ps
// Directed bench for axi_mem_arbiter. Two instances share all inputs:
// dut_a uses LSU priority, dut_b uses round-robin. Each test resets both.
module tb_axi_mem_arbiter;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned ID_W   = 4;
   localparam int unsigned STRB_W = DATA_W/8;

   logic clk, rst;
   int   n_total, n_pass;

   // shared stimulus
   logic              m0_arvalid, m0_rready, m1_arvalid, m1_rready;
   logic [ADDR_W-1:0] m0_araddr, m1_araddr, m1_awaddr;
   logic [ID_W-1:0]   m0_arid, m1_arid, m1_awid;
   logic [7:0]        m0_arlen, m1_arlen, m1_awlen;
   logic [2:0]        m0_arsize, m1_arsize, m1_awsize;
   logic [1:0]        m0_arburst, m1_arburst, m1_awburst;
   logic              m1_awvalid, m1_wvalid, m1_wlast, m1_bready;
   logic [DATA_W-1:0] m1_wdata, s_rdata;
   logic [STRB_W-1:0] m1_wstrb;
   logic              s_arready, s_rvalid, s_rlast, s_awready, s_wready, s_bvalid;
   logic [1:0]        s_rresp, s_bresp;
   logic [ID_W-1:0]   s_rid, s_bid;

   // dut_a outputs
   logic              m0_arready, m0_rvalid, m0_rlast, m1_arready, m1_rvalid, m1_rlast;
   logic [DATA_W-1:0] m0_rdata, m1_rdata, s_wdata;
   logic [1:0]        m0_rresp, m1_rresp, m1_bresp, s_arburst, s_awburst, grant;
   logic [ID_W-1:0]   m0_rid, m1_rid, m1_bid, s_arid, s_awid;
   logic              m1_awready, m1_wready, m1_bvalid;
   logic              s_arvalid, s_rready, s_awvalid, s_wvalid, s_wlast, s_bready, busy;
   logic [ADDR_W-1:0] s_araddr, s_awaddr;
   logic [7:0]        s_arlen, s_awlen;
   logic [2:0]        s_arsize, s_awsize;
   logic [STRB_W-1:0] s_wstrb;

   // dut_b outputs
   logic              b_m0_arready, b_m0_rvalid, b_m0_rlast, b_m1_arready, b_m1_rvalid, b_m1_rlast;
   logic [DATA_W-1:0] b_m0_rdata, b_m1_rdata, b_s_wdata;
   logic [1:0]        b_m0_rresp, b_m1_rresp, b_m1_bresp, b_s_arburst, b_s_awburst, b_grant;
   logic [ID_W-1:0]   b_m0_rid, b_m1_rid, b_m1_bid, b_s_arid, b_s_awid;
   logic              b_m1_awready, b_m1_wready, b_m1_bvalid;
   logic              b_s_arvalid, b_s_rready, b_s_awvalid, b_s_wvalid, b_s_wlast, b_s_bready, b_busy;
   logic [ADDR_W-1:0] b_s_araddr, b_s_awaddr;
   logic [7:0]        b_s_arlen, b_s_awlen;
   logic [2:0]        b_s_arsize, b_s_awsize;
   logic [STRB_W-1:0] b_s_wstrb;

   logic [11:0] vr_a, vr_b;
   assign vr_a = {m0_arready, m0_rvalid, m1_arready, m1_rvalid, m1_awready, m1_wready,
                  m1_bvalid, s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready};
   assign vr_b = {b_m0_arready, b_m0_rvalid, b_m1_arready, b_m1_rvalid, b_m1_awready, b_m1_wready,
                  b_m1_bvalid, b_s_arvalid, b_s_rready, b_s_awvalid, b_s_wvalid, b_s_bready};

   axi_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .LSU_PRIO(1)) dut_a (
      .clk(clk), .rst(rst),
      .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr), .m0_arid(m0_arid),
      .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
      .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
      .m0_rlast(m0_rlast), .m0_rid(m0_rid),
      .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr), .m1_arid(m1_arid),
      .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
      .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
      .m1_rlast(m1_rlast), .m1_rid(m1_rid),
      .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awaddr(m1_awaddr), .m1_awid(m1_awid),
      .m1_awlen(m1_awlen), .m1_awsize(m1_awsize), .m1_awburst(m1_awburst),
      .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
      .m1_wlast(m1_wlast), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_bresp(m1_bresp),
      .m1_bid(m1_bid),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
      .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
      .s_rlast(s_rlast), .s_rid(s_rid),
      .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid),
      .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
      .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
      .s_wlast(s_wlast), .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
      .s_bid(s_bid), .grant(grant), .busy(busy)
   );

   axi_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .LSU_PRIO(0)) dut_b (
      .clk(clk), .rst(rst),
      .m0_arvalid(m0_arvalid), .m0_arready(b_m0_arready), .m0_araddr(m0_araddr), .m0_arid(m0_arid),
      .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
      .m0_rvalid(b_m0_rvalid), .m0_rready(m0_rready), .m0_rdata(b_m0_rdata), .m0_rresp(b_m0_rresp),
      .m0_rlast(b_m0_rlast), .m0_rid(b_m0_rid),
      .m1_arvalid(m1_arvalid), .m1_arready(b_m1_arready), .m1_araddr(m1_araddr), .m1_arid(m1_arid),
      .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
      .m1_rvalid(b_m1_rvalid), .m1_rready(m1_rready), .m1_rdata(b_m1_rdata), .m1_rresp(b_m1_rresp),
      .m1_rlast(b_m1_rlast), .m1_rid(b_m1_rid),
      .m1_awvalid(m1_awvalid), .m1_awready(b_m1_awready), .m1_awaddr(m1_awaddr), .m1_awid(m1_awid),
      .m1_awlen(m1_awlen), .m1_awsize(m1_awsize), .m1_awburst(m1_awburst),
      .m1_wvalid(m1_wvalid), .m1_wready(b_m1_wready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
      .m1_wlast(m1_wlast), .m1_bvalid(b_m1_bvalid), .m1_bready(m1_bready), .m1_bresp(b_m1_bresp),
      .m1_bid(b_m1_bid),
      .s_arvalid(b_s_arvalid), .s_arready(s_arready), .s_araddr(b_s_araddr), .s_arid(b_s_arid),
      .s_arlen(b_s_arlen), .s_arsize(b_s_arsize), .s_arburst(b_s_arburst),
      .s_rvalid(s_rvalid), .s_rready(b_s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
      .s_rlast(s_rlast), .s_rid(s_rid),
      .s_awvalid(b_s_awvalid), .s_awready(s_awready), .s_awaddr(b_s_awaddr), .s_awid(b_s_awid),
      .s_awlen(b_s_awlen), .s_awsize(b_s_awsize), .s_awburst(b_s_awburst),
      .s_wvalid(b_s_wvalid), .s_wready(s_wready), .s_wdata(b_s_wdata), .s_wstrb(b_s_wstrb),
      .s_wlast(b_s_wlast), .s_bvalid(s_bvalid), .s_bready(b_s_bready), .s_bresp(s_bresp),
      .s_bid(s_bid), .grant(b_grant), .busy(b_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      m0_arvalid = 0; m0_rready = 0; m0_araddr = '0; m0_arid = '0; m0_arlen = '0;
      m0_arsize = 3'd2; m0_arburst = 2'b01;
      m1_arvalid = 0; m1_rready = 0; m1_araddr = '0; m1_arid = '0; m1_arlen = '0;
      m1_arsize = 3'd2; m1_arburst = 2'b01;
      m1_awvalid = 0; m1_awaddr = '0; m1_awid = '0; m1_awlen = '0; m1_awsize = 3'd2;
      m1_awburst = 2'b01; m1_wvalid = 0; m1_wdata = '0; m1_wstrb = '0; m1_wlast = 0;
      m1_bready = 0;
      s_arready = 0; s_rvalid = 0; s_rdata = '0; s_rresp = '0; s_rlast = 0; s_rid = '0;
      s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = '0; s_bid = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      repeat (2) step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      // spurious R/B beats in IDLE must not be routed
      s_rvalid = 1; s_rlast = 1; s_bvalid = 1; m0_rready = 1; m1_rready = 1; m1_bready = 1;
      @(negedge clk);
      n_total++; if (grant !== 2'b00) $display("FAIL reset_grant: got %b want 00", grant); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
      n_total++; if (vr_a !== 12'h000) $display("FAIL reset_vr_a: got %h want 000", vr_a); else n_pass++;
      n_total++; if (vr_b !== 12'h000) $display("FAIL reset_vr_b: got %h want 000", vr_b); else n_pass++;
      step();
      clear_inputs();
   endtask

   task automatic test_m0_alone();
      do_reset();
      m0_arvalid = 1; m0_araddr = 32'h8000_0000; m0_arid = 4'h3; m0_rready = 1;
      @(negedge clk);
      n_total++; if (s_arvalid !== 1'b0) $display("FAIL m0_ar_latency: got %b want 0", s_arvalid); else n_pass++;
      step();
      s_arready = 1;
      @(negedge clk);
      n_total++; if (grant !== 2'b01) $display("FAIL m0_grant: got %b want 01", grant); else n_pass++;
      n_total++; if (s_arvalid !== 1'b1) $display("FAIL m0_s_arvalid: got %b want 1", s_arvalid); else n_pass++;
      n_total++; if (s_araddr !== 32'h8000_0000) $display("FAIL m0_s_araddr: got %h want 80000000", s_araddr); else n_pass++;
      n_total++; if (s_arid !== 4'h3) $display("FAIL m0_s_arid: got %h want 3", s_arid); else n_pass++;
      n_total++; if (m0_arready !== 1'b1) $display("FAIL m0_arready: got %b want 1", m0_arready); else n_pass++;
      step();
      // master still asserts arvalid; the AR must not be re-issued
      s_arready = 0; s_rvalid = 1; s_rdata = 32'h0000_0013; s_rlast = 1; s_rid = 4'h3;
      @(negedge clk);
      n_total++; if (s_arvalid !== 1'b0) $display("FAIL m0_ar_masked: got %b want 0", s_arvalid); else n_pass++;
      n_total++; if (m0_rvalid !== 1'b1) $display("FAIL m0_rvalid: got %b want 1", m0_rvalid); else n_pass++;
      n_total++; if (m0_rdata !== 32'h0000_0013) $display("FAIL m0_rdata: got %h want 00000013", m0_rdata); else n_pass++;
      n_total++; if (m1_rvalid !== 1'b0) $display("FAIL m0_m1_rvalid: got %b want 0", m1_rvalid); else n_pass++;
      n_total++; if (s_rready !== 1'b1) $display("FAIL m0_s_rready: got %b want 1", s_rready); else n_pass++;
      step();
      m0_arvalid = 0; s_rvalid = 0; s_rlast = 0;
      @(negedge clk);
      n_total++; if (grant !== 2'b00) $display("FAIL m0_release_grant: got %b want 00", grant); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL m0_release_busy: got %b want 0", busy); else n_pass++;
      clear_inputs();
   endtask

   task automatic test_contested_prio();
      do_reset();
      m0_arvalid = 1; m0_araddr = 32'h0000_0100; m0_rready = 1;
      m1_arvalid = 1; m1_araddr = 32'h0000_0200; m1_rready = 1;
      step();
      s_arready = 1;
      @(negedge clk);
      n_total++; if (grant !== 2'b10) $display("FAIL prio_grant_m1: got %b want 10", grant); else n_pass++;
      n_total++; if (s_araddr !== 32'h0000_0200) $display("FAIL prio_araddr_m1: got %h want 00000200", s_araddr); else n_pass++;
      n_total++; if (m0_arready !== 1'b0) $display("FAIL prio_m0_arready_ar: got %b want 0", m0_arready); else n_pass++;
      step();
      m1_arvalid = 0; s_arready = 0; s_rvalid = 1; s_rlast = 1; s_rdata = 32'h0000_0011;
      @(negedge clk);
      n_total++; if (m1_rdata !== 32'h0000_0011 || m1_rvalid !== 1'b1) $display("FAIL prio_m1_r: got %b/%h want 1/00000011", m1_rvalid, m1_rdata); else n_pass++;
      n_total++; if (m0_rvalid !== 1'b0) $display("FAIL prio_m0_rvalid: got %b want 0", m0_rvalid); else n_pass++;
      step();
      s_rvalid = 0; s_rlast = 0;
      @(negedge clk);
      n_total++; if (grant !== 2'b00) $display("FAIL prio_idle_gap: got %b want 00", grant); else n_pass++;
      step();
      s_arready = 1;
      @(negedge clk);
      n_total++; if (grant !== 2'b01) $display("FAIL prio_grant_m0: got %b want 01", grant); else n_pass++;
      n_total++; if (s_araddr !== 32'h0000_0100) $display("FAIL prio_araddr_m0: got %h want 00000100", s_araddr); else n_pass++;
      step();
      m0_arvalid = 0; s_arready = 0; s_rvalid = 1; s_rlast = 1;
      step();
      clear_inputs();
   endtask

   task automatic test_round_robin();
      logic [1:0] exp;
      do_reset();
      m0_rready = 1; m1_rready = 1;
      for (int i = 0; i < 4; i++) begin
         m0_arvalid = 1; m1_arvalid = 1; s_rvalid = 0; s_rlast = 0;
         @(negedge clk);
         n_total++; if (b_grant !== 2'b00) $display("FAIL rr_idle_%0d: got %b want 00", i, b_grant); else n_pass++;
         step();
         s_arready = 1;
         exp = (i % 2 == 0) ? 2'b01 : 2'b10;
         @(negedge clk);
         n_total++; if (b_grant !== exp) $display("FAIL rr_round_%0d: got %b want %b", i, b_grant, exp); else n_pass++;
         step();
         s_arready = 0; s_rvalid = 1; s_rlast = 1;
         step();
      end
      clear_inputs();
   endtask

   task automatic test_write_aw_first();
      do_reset();
      m1_awvalid = 1; m1_awaddr = 32'h0000_0040; m1_awid = 4'h5; m1_bready = 1;
      step();
      s_awready = 1;
      @(negedge clk);
      n_total++; if (grant !== 2'b10) $display("FAIL wr_grant: got %b want 10", grant); else n_pass++;
      n_total++; if (s_awvalid !== 1'b1 || s_awaddr !== 32'h0000_0040) $display("FAIL wr_aw: got %b/%h want 1/00000040", s_awvalid, s_awaddr); else n_pass++;
      n_total++; if (m1_awready !== 1'b1) $display("FAIL wr_awready: got %b want 1", m1_awready); else n_pass++;
      n_total++; if (s_wvalid !== 1'b0) $display("FAIL wr_wvalid_early: got %b want 0", s_wvalid); else n_pass++;
      step();
      s_awready = 0;
      @(negedge clk);
      n_total++; if (s_awvalid !== 1'b0) $display("FAIL wr_aw_masked: got %b want 0", s_awvalid); else n_pass++;
      step();
      m1_wvalid = 1; m1_wdata = 32'hDEAD_BEEF; m1_wstrb = 4'hF; m1_wlast = 1; s_wready = 1;
      @(negedge clk);
      n_total++; if (s_wvalid !== 1'b1 || s_wdata !== 32'hDEAD_BEEF) $display("FAIL wr_w: got %b/%h want 1/deadbeef", s_wvalid, s_wdata); else n_pass++;
      n_total++; if (s_wstrb !== 4'hF || m1_wready !== 1'b1) $display("FAIL wr_wstrb: got %h/%b want f/1", s_wstrb, m1_wready); else n_pass++;
      n_total++; if (s_awvalid !== 1'b0) $display("FAIL wr_aw_reissue: got %b want 0", s_awvalid); else n_pass++;
      step();
      m1_awvalid = 0; m1_wvalid = 0; s_wready = 0; s_bvalid = 1; s_bresp = 2'b10; s_bid = 4'h5;
      @(negedge clk);
      n_total++; if (m1_bvalid !== 1'b1 || m1_bresp !== 2'b10) $display("FAIL wr_bresp: got %b/%b want 1/10", m1_bvalid, m1_bresp); else n_pass++;
      n_total++; if (m1_bid !== 4'h5 || s_bready !== 1'b1) $display("FAIL wr_bid: got %h/%b want 5/1", m1_bid, s_bready); else n_pass++;
      n_total++; if (busy !== 1'b1) $display("FAIL wr_busy_b: got %b want 1", busy); else n_pass++;
      step();
      s_bvalid = 0;
      @(negedge clk);
      n_total++; if (busy !== 1'b0 || grant !== 2'b00) $display("FAIL wr_release: got %b/%b want 0/00", busy, grant); else n_pass++;
      clear_inputs();
   endtask

   task automatic test_write_vs_read();
      do_reset();
      m1_awvalid = 1; m1_wvalid = 1; m1_wlast = 1; m1_bready = 1;
      m0_arvalid = 1; m0_araddr = 32'h0000_0300; m0_rready = 1;
      step();
      s_arready = 1; s_awready = 1; s_wready = 1;
      @(negedge clk);
      n_total++; if (grant !== 2'b10) $display("FAIL wvr_grant_wr: got %b want 10", grant); else n_pass++;
      n_total++; if (m0_arready !== 1'b0 || s_arvalid !== 1'b0) $display("FAIL wvr_m0_blocked: got %b/%b want 0/0", m0_arready, s_arvalid); else n_pass++;
      n_total++; if (s_awvalid !== 1'b1 || s_wvalid !== 1'b1) $display("FAIL wvr_aw_w_same: got %b/%b want 1/1", s_awvalid, s_wvalid); else n_pass++;
      step();
      m1_awvalid = 0; m1_wvalid = 0; s_arready = 0; s_awready = 0; s_wready = 0; s_bvalid = 1;
      step();
      s_bvalid = 0;
      @(negedge clk);
      n_total++; if (grant !== 2'b00) $display("FAIL wvr_idle: got %b want 00", grant); else n_pass++;
      step();
      s_arready = 1;
      @(negedge clk);
      n_total++; if (grant !== 2'b01 || s_arvalid !== 1'b1) $display("FAIL wvr_grant_rd: got %b/%b want 01/1", grant, s_arvalid); else n_pass++;
      step();
      m0_arvalid = 0; s_arready = 0; s_rvalid = 1; s_rlast = 1;
      step();
      clear_inputs();
   endtask

   task automatic test_reset_mid_read();
      do_reset();
      m0_arvalid = 1; m0_arlen = 8'd3; m0_rready = 1;
      step();
      s_arready = 1;
      step();
      m0_arvalid = 0; s_arready = 0; s_rvalid = 1; s_rlast = 0;
      step();
      step();
      // reset is sampled at the next edge; the beat is still routed this cycle
      rst = 1; m0_arvalid = 1;
      @(negedge clk);
      n_total++; if (m0_rvalid !== 1'b1 || grant !== 2'b01) $display("FAIL rstmid_sync: got %b/%b want 1/01", m0_rvalid, grant); else n_pass++;
      step();
      @(negedge clk);
      n_total++; if (grant !== 2'b00 || busy !== 1'b0) $display("FAIL rstmid_state: got %b/%b want 00/0", grant, busy); else n_pass++;
      n_total++; if (vr_a !== 12'h000) $display("FAIL rstmid_vr_a: got %h want 000", vr_a); else n_pass++;
      n_total++; if (vr_b !== 12'h000 || b_grant !== 2'b00) $display("FAIL rstmid_vr_b: got %h/%b want 000/00", vr_b, b_grant); else n_pass++;
      step();
      rst = 0;
      clear_inputs();
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;
      rst     = 1'b1;
      clear_inputs();
      test_reset();
      test_m0_alone();
      test_contested_prio();
      test_round_robin();
      test_write_aw_first();
      test_write_vs_read();
      test_reset_mid_read();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/axi_mem_arbiter.md
Name: axi_mem_arbiter

Overview:
- Two-master, one-slave AXI4 arbiter that shares the core's single memory AXI port.
- Master 0 is the instruction fetch unit (read-only). Master 1 is the load/store path in the write-back stage (read and write).
- Grants whole transactions: once a master wins, it owns the slave port until its final R beat or its B response completes.
- Sits between both masters and the top-level AXI master port (or crossbar).

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; WSTRB width = DATA_W/8
- ID_W, 4, AXI ID width, passed through unchanged
- LSU_PRIO, 1, 1 = master 1 has fixed priority over master 0; 0 = round-robin between the two read requesters

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- m0_ar{valid,ready,addr,id,len,size,burst}  in/out/in/in/in/in/in  1/1/ADDR_W/ID_W/8/3/2  IFU read address channel
- m0_r{valid,ready,data,resp,last,id}  out/in/out/out/out/out  1/1/DATA_W/2/1/ID_W  IFU read data channel
- m1_ar*, m1_r*  same as m0  LSU read channels
- m1_aw{valid,ready,addr,id,len,size,burst}  in/out/in/in/in/in/in  1/1/ADDR_W/ID_W/8/3/2  LSU write address channel
- m1_w{valid,ready,data,strb,last}  in/out/in/in/in  1/1/DATA_W/DATA_W/8/1  LSU write data channel
- m1_b{valid,ready,resp,id}  out/in/out/out  1/1/2/ID_W  LSU write response channel
- s_ar*, s_r*, s_aw*, s_w*, s_b*  mirrored directions  same widths  slave-side AXI port
- grant  out  2  one-hot current owner: 01 = m0, 10 = m1, 00 = none
- busy  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst). Reset forces the state machine to IDLE and the round-robin pointer to m0.
- Outputs in IDLE and after reset: grant = 00, busy = 0. All ready and valid outputs on both sides are 0. Data, address and ID outputs are don't-care, but the bench must not X-check them while the matching valid is 0.
- States: IDLE, RD_M0, RD_M1, WR_M1. State and grant are registered.
- Arbitration happens in IDLE only; the winner is evaluated from the current-cycle valids:
  - if m1_awvalid → WR_M1;
  - else if m1_arvalid && m0_arvalid → RD_M1 when LSU_PRIO = 1, otherwise the side the round-robin pointer favours, after which the pointer flips to the other side;
  - else whichever single arvalid is set;
  - else stay in IDLE.
- Arbitration latency: the request is seen in cycle N; the slave AR/AW is first driven in cycle N+1. Masters must hold valid and payload stable, as AXI requires.
- RD_Mx routing:
  - s_ar* = mx_ar*, mx_arready = s_arready;
  - mx_r* = s_r*, s_rready = mx_rready;
  - every other master sees arready = 0 and rvalid = 0.
  - The AR handshake is expected once; any later arvalid from the owner is ignored (s_arvalid is masked to 0 after the AR fires, tracked by an ar_done flag).
- WR_M1 routing:
  - AW and W are forwarded independently and may complete in either order or the same cycle;
  - each is masked after its handshake (aw_done, w_done);
  - B is routed to m1;
  - m0 sees arready = 0.
  - Write bursts are supported: W beats pass through until the beat with wlast = 1.
- Release:
  - RD_Mx → IDLE on the cycle after s_rvalid && s_rready && s_rlast;
  - WR_M1 → IDLE on the cycle after s_bvalid && s_bready.
  - Minimum one IDLE cycle between transactions.
- Responses (rresp, bresp, including SLVERR and DECERR) and IDs pass through unmodified; the arbiter never retries.
- Spurious beats: an R or B beat arriving in IDLE, or for a direction not in flight, is not routed. s_rready and s_bready stay 0.
- Reset mid-transaction: immediate return to IDLE and all outputs to their reset values. Slave-side recovery is the system reset's responsibility.
- The round-robin pointer updates only on a contested read grant.

Test Plan:
- m0 alone: m0_arvalid = 1, addr = 0x8000_0000, len = 0 → s_arvalid in the next cycle with the same address; an R beat with data 0x0000_0013 reaches m0_rdata; grant = 01, then 00 one cycle after rlast.
- Contested read, LSU_PRIO = 1: m0 and m1 arvalid in the same cycle → RD_M1 first; m0 is served after m1's R completes plus one IDLE cycle. m0_arready stays 0 throughout.
- Contested read, LSU_PRIO = 0, four back-to-back contested rounds → grant order m0, m1, m0, m1.
- LSU write with AW before W: AW accepted cycle 1, W (data 0xDEAD_BEEF, strb 0xF) cycle 3, bresp = 2'b10 → m1_bresp = 2'b10. AW is not re-issued; busy drops one cycle after the B handshake.
- Write vs read contention: m1_awvalid and m0_arvalid in the same cycle → WR_M1 granted first, then RD_M0.
- rst asserted mid-RD_M0 with len = 3 after two beats → the next cycle gives grant = 00, busy = 0, all valid and ready outputs 0.
